// File: rtl/dlx_mem_arbiter_if.sv
// Bus bundle between the DLX phase requesters (fetch/data), the arbiter and the memory model.
// The arbiter uses the slave view; requesters and memory together use the master view.
interface dlx_mem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic            i_req;
    logic [AW-1:0]   i_addr;
    logic [DW-1:0]   i_rdata;
    logic            i_ack;
    logic            i_err;

    logic            d_req;
    logic            d_we;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic [DW/8-1:0] d_be;
    logic [DW-1:0]   d_rdata;
    logic            d_ack;
    logic            d_err;

    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_be;
    logic [DW-1:0]   mem_rdata;
    logic            mem_ready;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata, mem_ready,
        output i_rdata, i_ack, i_err, d_rdata, d_ack, d_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata, mem_ready,
        input  i_rdata, i_ack, i_err, d_rdata, d_ack, d_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/dlx_mem_arbiter.sv
// Arbitrates the single-ported DLX memory between instruction fetch and data access,
// with registered memory-side attributes, wait-state tolerance and an access timeout.
module dlx_mem_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    dlx_mem_arbiter_if.slave     bus
);
    localparam int unsigned BW = DW / 8;
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e          state_q, state_d;
    logic            gnt_data_q, gnt_data_d;
    logic            last_data_q, last_data_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [BW-1:0]   be_q, be_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            take_data;
    logic            resp;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            gnt_data_q  <= 1'b0;
            last_data_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_data_q  <= gnt_data_d;
            last_data_q <= last_data_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_data_d  = gnt_data_q;
        last_data_d = last_data_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        // On a tie the side that did not win last time gets the grant.
        take_data   = bus.d_req && (!bus.i_req || !last_data_q);

        case (state_q)
            StIdle: begin
                if (bus.i_req || bus.d_req) begin
                    gnt_data_d  = take_data;
                    last_data_d = take_data;
                    we_d        = take_data && bus.d_we;
                    addr_d      = take_data ? bus.d_addr : bus.i_addr;
                    wdata_d     = take_data ? bus.d_wdata : '0;
                    be_d        = take_data ? bus.d_be : '1;
                    err_d       = 1'b0;
                    cnt_d       = '0;
                    state_d     = StAccess;
                end
            end
            StAccess: begin
                if (bus.mem_ready) begin
                    if (!we_q) rdata_d = bus.mem_rdata;
                    state_d = StResp;
                end else begin
                    if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + CW'(1);
                    if (TIMEOUT != 0 && cnt_d == CW'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign resp          = (state_q == StResp);
    assign bus.mem_req   = (state_q == StAccess);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_be    = be_q;
    assign bus.i_ack     = resp && !gnt_data_q;
    assign bus.i_err     = resp && !gnt_data_q && err_q;
    assign bus.d_ack     = resp && gnt_data_q;
    assign bus.d_err     = resp && gnt_data_q && err_q;
    assign bus.i_rdata   = rdata_q;
    assign bus.d_rdata   = rdata_q;
endmodule

// File: tb/tb_dlx_mem_arbiter.sv
// Directed bench for dlx_mem_arbiter (TIMEOUT = 4): fetch, load with waits, store,
// contention, timeout and reset-during-access scenarios.
module tb_dlx_mem_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    dlx_mem_arbiter_if #(.AW(32), .DW(32)) bus ();

    dlx_mem_arbiter #(
        .AW      (32),
        .DW      (32),
        .TIMEOUT (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.i_req = 1'b0;  bus.i_addr = '0;
        bus.d_req = 1'b0;  bus.d_we = 1'b0;  bus.d_addr = '0;
        bus.d_wdata = '0;  bus.d_be = '0;
        bus.mem_rdata = '0; bus.mem_ready = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_mem_be", 32'(bus.mem_be), 32'h0);
        chk("rst_acks", {28'd0, bus.i_ack, bus.d_ack, bus.i_err, bus.d_err}, 32'h0);
        chk("rst_rdata", bus.i_rdata, 32'h0);
        reset = 1'b0;
        tick();

        // Fetch, zero wait
        bus.i_req = 1'b1; bus.i_addr = 32'h100;
        chk("f_idle_mem_req", 32'(bus.mem_req), 32'd0);
        tick();
        chk("f_mem_req", 32'(bus.mem_req), 32'd1);
        chk("f_mem_we", 32'(bus.mem_we), 32'd0);
        chk("f_mem_addr", bus.mem_addr, 32'h100);
        chk("f_mem_be", 32'(bus.mem_be), 32'hF);
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
        tick();
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
        chk("f_i_ack", 32'(bus.i_ack), 32'd1);
        chk("f_i_err", 32'(bus.i_err), 32'd0);
        chk("f_i_rdata", bus.i_rdata, 32'hDEADBEEF);
        chk("f_d_ack", 32'(bus.d_ack), 32'd0);
        chk("f_resp_mem_req", 32'(bus.mem_req), 32'd0);
        tick();
        bus.i_req = 1'b0;
        chk("f_ack_pulse", 32'(bus.i_ack), 32'd0);

        // mem_ready while idle is ignored
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h99999999;
        tick();
        chk("idle_ready_ign", {30'd0, bus.mem_req, bus.i_ack}, 32'd0);
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
        tick();

        // Load, 3 wait states; attribute change during access is ignored
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h2000;
        tick();
        chk("ld_mem_addr", bus.mem_addr, 32'h2000);
        chk("ld_mem_we", 32'(bus.mem_we), 32'd0);
        bus.d_addr = 32'h3000;
        for (int i = 0; i < 3; i++) begin
            chk("ld_wait_mem_req", 32'(bus.mem_req), 32'd1);
            tick();
        end
        chk("ld_mem_req4", 32'(bus.mem_req), 32'd1);
        chk("ld_addr_latched", bus.mem_addr, 32'h2000);
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
        tick();
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
        chk("ld_d_ack", 32'(bus.d_ack), 32'd1);
        chk("ld_d_err", 32'(bus.d_err), 32'd0);
        chk("ld_d_rdata", bus.d_rdata, 32'hCAFEF00D);
        chk("ld_i_ack", 32'(bus.i_ack), 32'd0);
        chk("ld_resp_mem_req", 32'(bus.mem_req), 32'd0);
        tick();
        bus.d_req = 1'b0;
        chk("ld_ack_pulse", 32'(bus.d_ack), 32'd0);
        tick();

        // Store
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h40;
        bus.d_wdata = 32'h12345678; bus.d_be = 4'b0011;
        tick();
        chk("st_mem_we", 32'(bus.mem_we), 32'd1);
        chk("st_mem_wdata", bus.mem_wdata, 32'h12345678);
        chk("st_mem_be", 32'(bus.mem_be), 32'h3);
        chk("st_mem_addr", bus.mem_addr, 32'h40);
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h55555555;
        tick();
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
        chk("st_d_ack", 32'(bus.d_ack), 32'd1);
        chk("st_d_err", 32'(bus.d_err), 32'd0);
        chk("st_rdata_kept", bus.d_rdata, 32'hCAFEF00D);
        tick();
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_wdata = '0; bus.d_be = '0;
        tick();

        // Contention after reset: D, I, D, I
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = 32'h10;
        bus.d_req = 1'b1; bus.d_addr = 32'h20;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hA5A5A5A5;
        for (int g = 0; g < 4; g++) begin
            tick();
            chk("ct_mem_addr", bus.mem_addr, (g % 2 == 0) ? 32'h20 : 32'h10);
            tick();
            chk("ct_d_ack", 32'(bus.d_ack), (g % 2 == 0) ? 32'd1 : 32'd0);
            chk("ct_i_ack", 32'(bus.i_ack), (g % 2 == 0) ? 32'd0 : 32'd1);
            tick();
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
        tick();

        // Timeout: mem_req exactly 4 cycles then ack+err
        bus.d_req = 1'b1; bus.d_addr = 32'h80;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("to_mem_req", 32'(bus.mem_req), 32'd1);
        end
        tick();
        chk("to_mem_req_off", 32'(bus.mem_req), 32'd0);
        chk("to_d_ack", 32'(bus.d_ack), 32'd1);
        chk("to_d_err", 32'(bus.d_err), 32'd1);
        chk("to_d_rdata", bus.d_rdata, 32'h0);
        tick();
        bus.d_req = 1'b0;
        chk("to_err_pulse", {30'd0, bus.d_ack, bus.d_err}, 32'd0);
        bus.i_req = 1'b1; bus.i_addr = 32'h104;
        tick();
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0BADF00D;
        tick();
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
        chk("to_next_i_ack", 32'(bus.i_ack), 32'd1);
        chk("to_next_i_err", 32'(bus.i_err), 32'd0);
        chk("to_next_rdata", bus.i_rdata, 32'h0BADF00D);
        tick();
        bus.i_req = 1'b0;
        tick();

        // Reset during ACCESS cycle 2 kills the access
        bus.d_req = 1'b1; bus.d_addr = 32'h300;
        tick();
        tick();
        chk("rs_mem_req_acc2", 32'(bus.mem_req), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rs_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rs_no_ack", {28'd0, bus.i_ack, bus.d_ack, bus.i_err, bus.d_err}, 32'd0);
        tick();
        chk("rs_reissue_req", 32'(bus.mem_req), 32'd1);
        chk("rs_reissue_addr", bus.mem_addr, 32'h300);
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h00000077;
        tick();
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
        chk("rs_d_ack", 32'(bus.d_ack), 32'd1);
        chk("rs_d_err", 32'(bus.d_err), 32'd0);
        chk("rs_d_rdata", bus.d_rdata, 32'h00000077);
        tick();
        bus.d_req = 1'b0;
        chk("rs_idle", {30'd0, bus.mem_req, bus.d_ack}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
